// File: rtl/gpio_led_pwm.sv
// ---------------------------------------------------------------------------
// gpio_led_pwm
//
// Memory-mapped LED driver. It has a small register window on an iomem-style
// bus, and each LED channel can be driven off, on, as PWM, or as PWM gated by
// a slow blink phase.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00        CTRL : [0] EN, [15:8] PRESC, [23:16] BLINKDIV
//   4*(n+1)     CHn  : [PWM_BITS-1:0] DUTY, [9:8] MODE
//   other       reads 0, writes ignored (still acknowledged)
//
// Ports:
//   clk          single clock, rising edge
//   resetn       synchronous active-low reset
//   iomem_valid  bus request
//   iomem_ready  one-cycle acknowledge, registered
//   iomem_wstrb  byte write strobes, all zero = read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready=1
//   led          LED drive, bit n = channel n (registered)
// ---------------------------------------------------------------------------
module gpio_led_pwm #(
    parameter int          NUM_CH    = 4,
    parameter int          PWM_BITS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic [NUM_CH-1:0] led
);

    localparam logic [PWM_BITS-1:0] PCNT_MAX = '1;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_PWM   = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic                ctrl_en;
    logic [7:0]          presc;
    logic [7:0]          blinkdiv;
    logic [PWM_BITS-1:0] duty [NUM_CH];
    logic [1:0]          mode [NUM_CH];

    // ------------------------------------------------------------------
    // Timebase state
    // ------------------------------------------------------------------
    logic [7:0]          presc_cnt;
    logic [PWM_BITS-1:0] pcnt;
    logic [7:0]          blink_cnt;
    logic                phase;
    logic                tick;
    logic                period_end;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic              hit;
    logic              accept;
    logic [5:0]        word_idx;
    logic              is_ctrl;
    logic [NUM_CH-1:0] ch_sel;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign hit      = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    // Blocking accept while ready is high forces a one-cycle gap between
    // acknowledges when a master holds valid across transactions.
    assign accept   = hit && !iomem_ready;
    assign word_idx = iomem_addr[7:2];
    assign is_ctrl  = (word_idx == 6'd0);

    // The byte-within-word bits and the unmapped write-data bits do not
    // reach any register.
    assign unused_bits = ^{iomem_addr[1:0], iomem_wdata, iomem_wstrb[3]};

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (word_idx == 6'(i + 1));
        end
    end

    always_comb begin
        rd_word = '0;
        if (is_ctrl) begin
            rd_word[0]     = ctrl_en;
            rd_word[15:8]  = presc;
            rd_word[23:16] = blinkdiv;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                rd_word[PWM_BITS-1:0] = duty[i];
                rd_word[9:8]          = mode[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and bus response.
    // rdata is captured from the pre-write contents on the same edge that
    // commits the write, so a write returns the old register value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            ctrl_en     <= 1'b0;
            presc       <= '0;
            blinkdiv    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty[i] <= '0;
                mode[i] <= '0;
            end
        end else begin
            iomem_ready <= accept;
            if (accept) begin
                iomem_rdata <= rd_word;
                if (is_ctrl) begin
                    if (iomem_wstrb[0]) ctrl_en  <= iomem_wdata[0];
                    if (iomem_wstrb[1]) presc    <= iomem_wdata[15:8];
                    if (iomem_wstrb[2]) blinkdiv <= iomem_wdata[23:16];
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_sel[i]) begin
                        if (iomem_wstrb[0]) duty[i] <= iomem_wdata[PWM_BITS-1:0];
                        if (iomem_wstrb[1]) mode[i] <= iomem_wdata[9:8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Timebase: prescaler -> PWM counter -> blink divider.
    // The >= compares let a lowered PRESC/BLINKDIV take effect on the next
    // wrap instead of running the counter all the way around.
    // ------------------------------------------------------------------
    assign tick       = ctrl_en && (presc_cnt >= presc);
    assign period_end = tick && (pcnt == PCNT_MAX);

    always_ff @(posedge clk) begin
        if (!resetn || !ctrl_en) begin
            presc_cnt <= '0;
            pcnt      <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (tick) begin
                presc_cnt <= '0;
                pcnt      <= pcnt + PWM_BITS'(1);
            end else begin
                presc_cnt <= presc_cnt + 8'd1;
            end
            if (period_end) begin
                if (blink_cnt >= blinkdiv) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // LED output stage
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] led_next;

    always_comb begin
        led_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            unique case (mode[i])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_PWM:   led_next[i] = (pcnt < duty[i]);
                MODE_BLINK: led_next[i] = (pcnt < duty[i]) && phase;
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led <= '0;
        end else begin
            led <= ctrl_en ? led_next : '0;
        end
    end

endmodule

// File: tb/tb_gpio_led_pwm.sv
module tb_gpio_led_pwm;

    localparam int          NUM_CH   = 4;
    localparam int          PWM_BITS = 8;
    localparam logic [31:0] BASE     = 32'h0300_0000;

    logic              clk = 1'b0;
    logic              resetn;
    logic              iomem_valid;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr;
    logic [31:0]       iomem_wdata;
    logic [31:0]       iomem_rdata;
    logic [NUM_CH-1:0] led;

    always #5 clk = ~clk;

    gpio_led_pwm #(
        .NUM_CH   (NUM_CH),
        .PWM_BITS (PWM_BITS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .led        (led)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference register images (readable bits only) and last expected rdata.
    logic [31:0] m_ctrl;
    logic [31:0] m_ch [NUM_CH];
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        int idx = int'(off) / 4;
        if (idx == 0) return m_ctrl;
        if (idx <= NUM_CH) return m_ch[idx-1];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] lanes;
        int idx = int'(off) / 4;
        lanes = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (idx == 0)
            m_ctrl = (m_ctrl & ~lanes) | (data & lanes & 32'h00FF_FF01);
        else if (idx <= NUM_CH)
            m_ch[idx-1] = (m_ch[idx-1] & ~lanes) | (data & lanes & 32'h0000_03FF);
    endtask

    task automatic model_reset();
        m_ctrl  = '0;
        m_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = '0;
    endtask

    // Expected led in cycle n counted from the cycle in which EN first reads 1.
    // Closed form: with P = PRESC+1, m cycles of counting give m/P ticks.
    function automatic logic [NUM_CH-1:0] exp_led(input int n);
        int m, p, t, pc, per, ph, duty, md;
        logic [NUM_CH-1:0] r;
        r = '0;
        if (n == 0 || m_ctrl[0] == 1'b0) return r;
        m   = n - 1;
        p   = int'(m_ctrl[15:8]) + 1;
        t   = m / p;
        pc  = t % (1 << PWM_BITS);
        per = t / (1 << PWM_BITS);
        ph  = (per / (int'(m_ctrl[23:16]) + 1)) % 2;
        for (int i = 0; i < NUM_CH; i++) begin
            duty = int'(m_ch[i][PWM_BITS-1:0]);
            md   = int'(m_ch[i][9:8]);
            case (md)
                0: r[i] = 1'b0;
                1: r[i] = 1'b1;
                2: r[i] = (pc < duty);
                default: r[i] = (pc < duty) && (ph == 1);
            endcase
        end
        return r;
    endfunction

    // One bus access. Returns at #1 after the edge that raised ready
    // (lat = cycles to ready, 0 if none within the bound).
    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
        bit done;
        @(negedge clk);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        lat   = 0;
        rdata = '0;
        done  = 1'b0;
        for (int k = 1; k <= 8 && !done; k++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) begin
                lat   = k;
                rdata = iomem_rdata;
                done  = 1'b1;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] rd, old;
        int lat;
        old = model_read(off);
        bus_xfer(BASE | {24'h0, off}, strb, data, rd, lat);
        chk($sformatf("wr%02h_lat", off), lat, 1);
        chk($sformatf("wr%02h_old", off), rd, old);
        model_write(off, data, strb);
        m_rdata = old;
    endtask

    task automatic rd_chk(input logic [7:0] off);
        logic [31:0] rd;
        int lat;
        bus_xfer(BASE | {24'h0, off}, 4'h0, 32'h0, rd, lat);
        chk($sformatf("rd%02h_lat", off), lat, 1);
        chk($sformatf("rd%02h_data", off), rd, model_read(off));
        m_rdata = model_read(off);
    endtask

    // Call right after the write that sets EN: first negedge is cycle 0.
    task automatic run_pwm(input string tag, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            chk($sformatf("%s_led@%0d", tag, n), {28'h0, led}, {28'h0, exp_led(n)});
        end
    endtask

    task automatic disable_and_check();
        wr(8'h00, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("off_led", {28'h0, led}, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  md;
        logic [7:0]  dt;

        model_reset();
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_led", {28'h0, led}, 32'h0);
        resetn = 1'b1;
        for (int i = 0; i <= NUM_CH; i++) rd_chk(8'(4 * i));

        // CTRL write/readback, then ready spacing with valid held high.
        wr(8'h00, 32'h0000_0301, 4'hF);
        rd_chk(8'h00);
        @(negedge clk);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE;
        iomem_wstrb = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ready_pulse%0d", k), {31'h0, iomem_ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
        end
        iomem_valid = 1'b0;

        // Byte-lane write.
        wr(8'h00, 32'h0000_0001, 4'hF);
        wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
        rd_chk(8'h00);
        chk("byte_wr_val", model_read(8'h00), 32'h0000_FF01);

        // Miss outside the window: no ready, rdata and registers untouched.
        @(negedge clk);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h100;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("miss_ready", {31'h0, iomem_ready}, 32'h0);
            chk("miss_rdata", iomem_rdata, m_rdata);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        rd_chk(8'h00);

        // Unmapped offset inside the window.
        wr(8'h40, 32'hFFFF_FFFF, 4'hF);
        rd_chk(8'h40);
        for (int i = 1; i <= NUM_CH; i++) rd_chk(8'(4 * i));

        // Directed PWM: PRESC=0, ch0 PWM DUTY=0x40.
        disable_and_check();
        wr(8'h04, 32'h0000_0240, 4'hF);
        wr(8'h00, 32'h0000_0001, 4'hF);
        run_pwm("pwm40", 600);

        // Directed blink: ch1 MODE=11 DUTY=0xFF, BLINKDIV=1.
        disable_and_check();
        wr(8'h04, 32'h0, 4'hF);
        wr(8'h08, 32'h0000_03FF, 4'hF);
        wr(8'h00, 32'h0001_0001, 4'hF);
        run_pwm("blink", 1100);

        // Randomized configurations.
        for (int r = 0; r < 5; r++) begin
            disable_and_check();
            for (int i = 0; i < NUM_CH; i++) begin
                md = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       dt = 8'h00;
                    1:       dt = 8'hFF;
                    default: dt = 8'($urandom);
                endcase
                d = $urandom;
                d[9:0] = {md, dt};
                wr(8'(4 * (i + 1)), d, 4'hF);
            end
            d = $urandom;
            d[23:16] = 8'($urandom_range(0, 1));
            d[15:8]  = 8'($urandom_range(0, 2));
            d[0]     = 1'b1;
            wr(8'h00, d, 4'hF);
            run_pwm($sformatf("rnd%0d", r), 1500);
        end

        // Reset during active PWM with a request held.
        disable_and_check();
        wr(8'h04, 32'h0000_0280, 4'hF);
        wr(8'h00, 32'h0000_0001, 4'hF);
        run_pwm("pre_rst", 200);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h4;
        iomem_wstrb = 4'h0;
        resetn      = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_led", {28'h0, led}, 32'h0);
        chk("rst_mid_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst_mid_rdata", iomem_rdata, 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_ready", {31'h0, iomem_ready}, 32'h0);
            chk("post_rst_led", {28'h0, led}, 32'h0);
        end
        for (int i = 0; i <= NUM_CH; i++) rd_chk(8'(4 * i));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
